// File: rtl/pwd_pkg.sv
// Shared definitions for the password keypad path: per-channel debounce
// states, the default debounce length and the one-hot key encoding that the
// downstream checker FSM also decodes.
package pwd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PWAIT = 2'd1,
        DOWN  = 2'd2,
        RWAIT = 2'd3
    } ch_state_t;

    localparam int unsigned DB_CYCLES_DEF = 1_000_000;
    localparam int unsigned CNT_W_DEF     = 20;

    // One-hot key encoding; digit 0 sits on the most significant bit.
    localparam logic [3:0] KEY0 = 4'b1000;
    localparam logic [3:0] KEY1 = 4'b0100;
    localparam logic [3:0] KEY2 = 4'b0010;
    localparam logic [3:0] KEY3 = 4'b0001;

    // Channel i (btn_raw[i]) carries digit 3-i.
    function automatic logic [1:0] ch_to_digit(input logic [1:0] ch);
        return 2'd3 - ch;
    endfunction

    // Binary digit to the one-hot key code.
    function automatic logic [3:0] digit_to_key(input logic [1:0] digit);
        logic [3:0] key;
        case (digit)
            2'd0:    key = KEY0;
            2'd1:    key = KEY1;
            2'd2:    key = KEY2;
            default: key = KEY3;
        endcase
        return key;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single-button conditioner: 2-flop synchroniser, debounce counter and a
// four-state press/release FSM. press_evt is a one-cycle strobe that rises
// on the cycle before the FSM enters DOWN, so the top-level register
// captures it at the same edge the channel becomes DOWN.
module key_debounce_ch
    import pwd_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       press_evt,
    output logic       busy,
    output logic       level,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    ch_state_t        state;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce FSM; the counter is cleared on every state change so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= PWAIT;
                        cnt   <= '0;
                    end
                end
                PWAIT: begin
                    if (!sync2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (!sync2) begin
                        state <= RWAIT;
                        cnt   <= '0;
                    end
                end
                RWAIT: begin
                    if (sync2) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign press_evt = (state == PWAIT) && sync2 && (cnt == CNT_LAST);
    assign busy      = (state != IDLE);
    assign level     = (state == DOWN) || (state == RWAIT);
    assign state_dbg = state;

endmodule

// File: rtl/pwd_key_debounce.sv
// Keypad front end: four debounced channels plus a registered accept/encode
// stage. A press is passed on only when it is the sole event and no other
// button is anywhere in its press/release cycle; anything else raises
// multi_err for one cycle instead. ch_state exposes the four channel states
// (channel i in bits [2i+1:2i]) for observation.
module pwd_key_debounce
    import pwd_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] s,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       multi_err,
    output logic [3:0] held,
    output logic [7:0] ch_state
);

    logic [3:0] press_evt;
    logic [3:0] busy;
    logic [3:0] level;
    logic       accept;
    logic [1:0] evt_digit;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (btn_raw[i]),
            .press_evt (press_evt[i]),
            .busy      (busy[i]),
            .level     (level[i]),
            .state_dbg (ch_state[2*i +: 2])
        );
    end

    assign held = level;

    // Accept only a lone press event with every other channel idle.
    always_comb begin
        evt_digit = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (press_evt[i]) evt_digit = ch_to_digit(2'(i));
        end
        accept = (press_evt != 4'd0)
              && ((press_evt & (press_evt - 4'd1)) == 4'd0)
              && ((busy & ~press_evt) == 4'd0);
    end

    // Registered key pulse / error pulse output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s         <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 2'd0;
            multi_err <= 1'b0;
        end else if (accept) begin
            s         <= digit_to_key(evt_digit);
            key_valid <= 1'b1;
            key_code  <= evt_digit;
            multi_err <= 1'b0;
        end else begin
            s         <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 2'd0;
            multi_err <= |press_evt;
        end
    end

endmodule

// File: tb/tb_pwd_key_debounce.sv
// Directed bench for pwd_key_debounce with DB_CYCLES=4. Inputs change on the
// falling edge; a monitor samples outputs 1 time unit after each rising edge
// and records pulses with the rising-edge count at which they appeared.
module tb_pwd_key_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] s;
    logic       key_valid;
    logic [1:0] key_code;
    logic       multi_err;
    logic [3:0] held;
    logic [7:0] ch_state;

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;

    int         s_cnt;
    int         err_cnt;
    int         s_cyc;
    int         err_cyc;
    int         bad_cnt;
    logic [3:0] last_s;
    logic [1:0] last_code;
    logic [1:0] obs_q[$];
    logic [1:0] exp_q[$];

    pwd_key_debounce #(
        .DB_CYCLES (4),
        .CNT_W     (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .s         (s),
        .key_valid (key_valid),
        .key_code  (key_code),
        .multi_err (multi_err),
        .held      (held),
        .ch_state  (ch_state)
    );

    // Clock and rising-edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (s != 4'd0) begin
                s_cnt++;
                last_s    = s;
                last_code = key_code;
                s_cyc     = cyc;
                obs_q.push_back(key_code);
            end
            if (multi_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (key_valid !== (s != 4'd0)) bad_cnt++;
            if (!key_valid && key_code != 2'd0) bad_cnt++;
            if ($countones(s) > 1) bad_cnt++;
        end
    end

    task automatic clear_mon();
        s_cnt     = 0;
        err_cnt   = 0;
        s_cyc     = -1;
        err_cyc   = -1;
        bad_cnt   = 0;
        last_s    = 4'd0;
        last_code = 2'd0;
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        btn_raw = 4'd0;
        repeat (3) @(negedge clk);
        tests_run++; if (s !== 4'd0) begin fails++; $display("FAIL reset_s: got %b want 0000", s); end
        tests_run++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        tests_run++; if (key_code !== 2'd0) begin fails++; $display("FAIL reset_key_code: got %b want 00", key_code); end
        tests_run++; if (multi_err !== 1'b0) begin fails++; $display("FAIL reset_multi_err: got %b want 0", multi_err); end
        tests_run++; if (ch_state !== 8'h00) begin fails++; $display("FAIL reset_ch_state: got %h want 00", ch_state); end
        btn_raw = 4'b1111;
        repeat (8) @(negedge clk);
        tests_run++; if (held !== 4'd0) begin fails++; $display("FAIL reset_held_btn: got %b want 0000", held); end
        tests_run++; if (s !== 4'd0) begin fails++; $display("FAIL reset_s_btn: got %b want 0000", s); end
        btn_raw = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int t0;
        clear_mon();
        @(negedge clk);
        btn_raw = 4'b0100;
        t0 = cyc + 1;
        repeat (6) @(negedge clk);
        tests_run++; if (held !== 4'b0000) begin fails++; $display("FAIL clean_held_before: got %b want 0000", held); end
        @(negedge clk);
        tests_run++; if (held !== 4'b0100) begin fails++; $display("FAIL clean_held_down: got %b want 0100", held); end
        repeat (3) @(negedge clk);
        btn_raw = 4'd0;
        repeat (6) @(negedge clk);
        tests_run++; if (held !== 4'b0100) begin fails++; $display("FAIL clean_held_rwait: got %b want 0100", held); end
        @(negedge clk);
        tests_run++; if (held !== 4'b0000) begin fails++; $display("FAIL clean_held_release: got %b want 0000", held); end
        repeat (4) @(negedge clk);
        tests_run++; if (s_cnt !== 1) begin fails++; $display("FAIL clean_pulse_count: got %0d want 1", s_cnt); end
        tests_run++; if (last_s !== 4'b0100) begin fails++; $display("FAIL clean_s: got %b want 0100", last_s); end
        tests_run++; if (last_code !== 2'b01) begin fails++; $display("FAIL clean_code: got %b want 01", last_code); end
        tests_run++; if (s_cyc !== t0 + 6) begin fails++; $display("FAIL clean_latency: got edge %0d want %0d", s_cyc, t0 + 6); end
        tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL clean_err: got %0d want 0", err_cnt); end
        tests_run++; if (bad_cnt !== 0) begin fails++; $display("FAIL clean_consistency: got %0d bad samples want 0", bad_cnt); end
    endtask

    task automatic test_bounce();
        int t0;
        clear_mon();
        @(negedge clk); btn_raw = 4'b0001;
        @(negedge clk); btn_raw = 4'b0000;
        @(negedge clk); btn_raw = 4'b0001;
        @(negedge clk); btn_raw = 4'b0000;
        @(negedge clk); btn_raw = 4'b0001;
        t0 = cyc + 1;
        repeat (6) @(negedge clk);
        tests_run++; if (s_cnt !== 0) begin fails++; $display("FAIL bounce_early: got %0d pulses want 0", s_cnt); end
        repeat (4) @(negedge clk);
        btn_raw = 4'd0;
        repeat (10) @(negedge clk);
        tests_run++; if (s_cnt !== 1) begin fails++; $display("FAIL bounce_count: got %0d want 1", s_cnt); end
        tests_run++; if (last_s !== 4'b0001) begin fails++; $display("FAIL bounce_s: got %b want 0001", last_s); end
        tests_run++; if (last_code !== 2'b11) begin fails++; $display("FAIL bounce_code: got %b want 11", last_code); end
        tests_run++; if (s_cyc !== t0 + 6) begin fails++; $display("FAIL bounce_latency: got edge %0d want %0d", s_cyc, t0 + 6); end

        // a 3-cycle glitch never reaches the end of the debounce window
        clear_mon();
        @(negedge clk); btn_raw = 4'b0010;
        repeat (3) @(negedge clk);
        btn_raw = 4'd0;
        repeat (10) @(negedge clk);
        tests_run++; if (s_cnt !== 0) begin fails++; $display("FAIL glitch_pulse: got %0d want 0", s_cnt); end
        tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL glitch_err: got %0d want 0", err_cnt); end
        tests_run++; if (held !== 4'd0) begin fails++; $display("FAIL glitch_held: got %b want 0000", held); end
    endtask

    task automatic test_simultaneous();
        int t0;
        clear_mon();
        @(negedge clk);
        btn_raw = 4'b1001;
        t0 = cyc + 1;
        repeat (10) @(negedge clk);
        tests_run++; if (s_cnt !== 0) begin fails++; $display("FAIL simul_pulse: got %0d want 0", s_cnt); end
        tests_run++; if (err_cnt !== 1) begin fails++; $display("FAIL simul_err_count: got %0d want 1", err_cnt); end
        tests_run++; if (err_cyc !== t0 + 6) begin fails++; $display("FAIL simul_err_edge: got %0d want %0d", err_cyc, t0 + 6); end
        tests_run++; if (held !== 4'b1001) begin fails++; $display("FAIL simul_held: got %b want 1001", held); end
        btn_raw = 4'd0;
        repeat (10) @(negedge clk);

        clear_mon();
        @(negedge clk);
        btn_raw = 4'b1000;
        t0 = cyc + 1;
        repeat (10) @(negedge clk);
        btn_raw = 4'd0;
        repeat (10) @(negedge clk);
        tests_run++; if (s_cnt !== 1) begin fails++; $display("FAIL after_simul_count: got %0d want 1", s_cnt); end
        tests_run++; if (last_s !== 4'b1000) begin fails++; $display("FAIL after_simul_s: got %b want 1000", last_s); end
        tests_run++; if (last_code !== 2'b00) begin fails++; $display("FAIL after_simul_code: got %b want 00", last_code); end
        tests_run++; if (s_cyc !== t0 + 6) begin fails++; $display("FAIL after_simul_latency: got %0d want %0d", s_cyc, t0 + 6); end
    endtask

    task automatic test_overlap();
        int t0;
        int t1;
        clear_mon();
        @(negedge clk);
        btn_raw = 4'b0010;
        t0 = cyc + 1;
        repeat (10) @(negedge clk);
        btn_raw = 4'b1010;
        t1 = cyc + 1;
        repeat (10) @(negedge clk);
        tests_run++; if (s_cnt !== 1) begin fails++; $display("FAIL overlap_count: got %0d want 1", s_cnt); end
        tests_run++; if (last_s !== 4'b0010) begin fails++; $display("FAIL overlap_s: got %b want 0010", last_s); end
        tests_run++; if (s_cyc !== t0 + 6) begin fails++; $display("FAIL overlap_latency: got %0d want %0d", s_cyc, t0 + 6); end
        tests_run++; if (err_cnt !== 1) begin fails++; $display("FAIL overlap_err_count: got %0d want 1", err_cnt); end
        tests_run++; if (err_cyc !== t1 + 6) begin fails++; $display("FAIL overlap_err_edge: got %0d want %0d", err_cyc, t1 + 6); end
        tests_run++; if (held !== 4'b1010) begin fails++; $display("FAIL overlap_held: got %b want 1010", held); end
        btn_raw = 4'd0;
        repeat (10) @(negedge clk);
        tests_run++; if (held !== 4'b0000) begin fails++; $display("FAIL overlap_release: got %b want 0000", held); end
    endtask

    task automatic test_reset_mid();
        int t_rel;
        clear_mon();
        @(negedge clk);
        btn_raw = 4'b0001;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++; if (ch_state !== 8'h00) begin fails++; $display("FAIL midrst_state: got %h want 00", ch_state); end
        repeat (2) @(negedge clk);
        tests_run++; if (s !== 4'd0) begin fails++; $display("FAIL midrst_s: got %b want 0000", s); end
        tests_run++; if (held !== 4'd0) begin fails++; $display("FAIL midrst_held: got %b want 0000", held); end
        rst = 1'b1;
        t_rel = cyc + 1;
        repeat (6) @(negedge clk);
        tests_run++; if (s_cnt !== 0) begin fails++; $display("FAIL midrst_early: got %0d pulses want 0", s_cnt); end
        @(negedge clk);
        tests_run++; if (s !== 4'b0001) begin fails++; $display("FAIL midrst_s_pulse: got %b want 0001", s); end
        tests_run++; if (s_cyc !== t_rel + 6) begin fails++; $display("FAIL midrst_latency: got %0d want %0d", s_cyc, t_rel + 6); end

        // reset in the middle of the pulse cancels it at once
        rst = 1'b0;
        #1;
        tests_run++; if (s !== 4'd0) begin fails++; $display("FAIL pulse_cancel_s: got %b want 0000", s); end
        tests_run++; if (key_valid !== 1'b0) begin fails++; $display("FAIL pulse_cancel_kv: got %b want 0", key_valid); end
        @(negedge clk);
        rst = 1'b1;
        t_rel = cyc + 1;
        repeat (10) @(negedge clk);
        tests_run++; if (s_cnt !== 2) begin fails++; $display("FAIL rerst_count: got %0d want 2", s_cnt); end
        tests_run++; if (s_cyc !== t_rel + 6) begin fails++; $display("FAIL rerst_latency: got %0d want %0d", s_cyc, t_rel + 6); end
        btn_raw = 4'd0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_sequence();
        logic [3:0] seq_keys [4];
        seq_keys = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        // checker code 8'b00011011 = digits 0,1,2,3
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3};
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            btn_raw = seq_keys[k];
            repeat (8) @(negedge clk);
            btn_raw = 4'd0;
            repeat (10) @(negedge clk);
        end
        tests_run++; if (obs_q.size() !== 4) begin fails++; $display("FAIL seq_count: got %0d keys want 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i >= obs_q.size()) begin
                fails++; $display("FAIL seq_digit%0d: got none want %0d", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL seq_digit%0d: got %0d want %0d", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL seq_err: got %0d want 0", err_cnt); end
        tests_run++; if (bad_cnt !== 0) begin fails++; $display("FAIL seq_consistency: got %0d bad samples want 0", bad_cnt); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_overlap();
        test_reset_mid();
        test_sequence();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
